legv8_fetch_unit: RTL and testbench
===================================

# legv8_fetch_unit

Instruction fetch stage for the LEGv8 core. It sits directly upstream of the control unit. It holds the program counter and issues word reads to instruction memory over a req/valid handshake. Fetched words are buffered in a 2-entry prefetch queue and presented to the control unit as `instruction` with their PC. The block also owns the 5-bit status flag register that feeds the control unit's `status` input, and it accepts branch redirects from the datapath.

## Interface
- `RESET_PC`, 64'h0: PC fetched first after reset; low 2 bits are required to be 0.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  64  byte address of the requested word, always word aligned.
- `imem_valid`  in  1  read data valid; sampled only on an edge where `imem_req`=1.
- `imem_data`  in  32  instruction word accompanying `imem_valid`.
- `instruction`  out  32  queue head, driven to the control unit.
- `instr_pc`  out  64  PC of `instruction`.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  control unit consumes the head this edge.
- `redirect`  in  1  branch taken; flush the queue and refetch.
- `redirect_target`  in  64  new PC; bits [1:0] are forced to 0.
- `status_we`  in  1  load the flag register.
- `status_in`  in  5  new flags.
- `status`  out  5  registered flags, driven to the control unit.

## Operation
- The FSM states are IDLE, FETCH, FULL and DRAIN.
- **IDLE** is entered only from reset. It goes to FETCH on the first edge with `reset` high.
- **FETCH** drives `imem_req`=1 and `imem_addr`=fetch_pc.
  - `imem_addr` must hold stable until `imem_valid`.
  - On an accepted response (req & valid, no redirect): enqueue {fetch_pc, imem_data} and set fetch_pc += 4 (64-bit wrap, no flag).
  - If the queue count after this edge is 2, go to FULL; otherwise stay in FETCH.
- **FULL** drives `imem_req`=0. It returns to FETCH on the edge where a dequeue occurs.
- **DRAIN** drives `imem_req`=1 with the old address.
  - The returning word is discarded.
  - On `imem_valid`, go to FETCH with fetch_pc = target.
- **Queue:** 2 entries. `instr_valid` = (count>0). A dequeue is `instr_valid & instr_ready`.
  - Enqueue and dequeue on the same edge leave count unchanged.
  - Enqueue never occurs when count=2.
- **Redirect** has priority over everything else on its edge:
  - the queue is cleared, and any dequeue or enqueue on that edge is ignored;
  - fetch_pc is set to `redirect_target & ~3`.
  - From FETCH with `imem_valid`=0 and `imem_req`=1, go to DRAIN and latch the target.
  - From FETCH with `imem_valid`=1, the word is dropped and the next state is FETCH.
  - From FULL or IDLE, go to FETCH.
  - A redirect while in DRAIN replaces the latched target.
- **Status:** `status` <= `status_in` when `status_we`=1, independent of the FSM.
- **Reset (async, any state, mid-request included):**
  - `imem_req`=0, `imem_addr`=RESET_PC, fetch_pc=RESET_PC;
  - queue empty, `instr_valid`=0, `instruction`=0, `instr_pc`=0;
  - `status`=0; state=IDLE.
  - Any memory response in flight is abandoned.

## Timing
- `imem_req`, `imem_addr`, `instr_*` and `status` are all registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- First request: `imem_req`=1 in the cycle after the first rising edge with `reset`=1.
- With a zero-wait memory (`imem_valid`=1 whenever requested) and `instr_ready`=1, throughput is one instruction per cycle.
- Fetch-to-`instr_valid` latency is 1 edge: a word accepted at edge N is visible at the head after edge N.
- Redirect-to-target-request latency:
  - 1 cycle if no request is pending;
  - otherwise 1 cycle after the drained `imem_valid`.
- A `status` write is visible the cycle after the `status_we` edge.

## Test plan
- **Reset then fetch:** release `reset`, zero-wait memory returns 32'h8B1F0040 at 0x0 and 32'hCB0003E0 at 0x4, `instr_ready`=1.
  - `imem_addr` sequence: 0x0, 0x4, 0x8.
  - `instruction`=8B1F0040 with `instr_pc`=0, then CB0003E0 with `instr_pc`=4 on consecutive cycles.
- **Backpressure:** hold `instr_ready`=0.
  - After 2 words, state is FULL, `imem_req`=0 and `imem_addr` holds 0x8.
  - One `instr_ready` pulse causes a single refetch at 0x8.
- **Redirect with wait-state memory:** memory delays 3 cycles; assert `redirect` with target 0x103 while the 0x4 request is pending.
  - `imem_req` stays high at 0x4 until valid, and that word is never seen on `instruction`.
  - The next request is at 0x100.
- **Simultaneous events:** with count=1, apply `redirect`, `imem_valid` and `instr_ready` on the same edge.
  - After the edge `instr_valid`=0 and the next `imem_addr` equals the target.
- **Status register:** `status_we`=1 with `status_in`=5'b10110 produces `status`=5'b10110 the next cycle and is held while `status_we`=0.
- **Reset mid-operation:** assert `reset`=0 asynchronously mid-cycle during DRAIN.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction fetch stage: PC, instruction-memory handshake, 2-entry
// prefetch queue, branch redirect handling and the status flag register.
module legv8_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    input  logic        status_we,
    input  logic [4:0]  status_in,
    output logic [4:0]  status
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] target_q, target_d;
    logic [63:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [31:0] head_ins_q, head_ins_d, tail_ins_q, tail_ins_d;
    logic [1:0]  count_q, count_d;
    logic [4:0]  status_q, status_d;

    logic [63:0] redirect_pc;
    logic        accept;
    logic        dequeue;

    always_comb begin
        redirect_pc = redirect_target & ~64'h3;
        accept      = (state_q == FETCH) && imem_valid && !redirect;
        dequeue     = (count_q != 2'd0) && instr_ready && !redirect;
    end

    // Head is always entry 0; a dequeue shifts the tail forward before any enqueue lands.
    always_comb begin
        head_pc_d  = head_pc_q;
        head_ins_d = head_ins_q;
        tail_pc_d  = tail_pc_q;
        tail_ins_d = tail_ins_q;
        count_d    = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (dequeue) begin
                head_pc_d  = tail_pc_q;
                head_ins_d = tail_ins_q;
                count_d    = count_q - 2'd1;
            end
            if (accept) begin
                if (count_d == 2'd0) begin
                    head_pc_d  = fetch_pc_q;
                    head_ins_d = imem_data;
                end else begin
                    tail_pc_d  = fetch_pc_q;
                    tail_ins_d = imem_data;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    // fetch_pc_q doubles as the request address, so in DRAIN it keeps the old
    // address while the redirect target waits in target_q.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        status_d   = status_we ? status_in : status_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_valid) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        state_d  = DRAIN;
                        target_d = redirect_pc;
                    end
                end else if (imem_valid) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    if (count_d == 2'd2) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    state_d    = FETCH;
                    fetch_pc_d = redirect_pc;
                end else if (dequeue) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    target_d = redirect_pc;
                end
                if (imem_valid) begin
                    state_d    = FETCH;
                    fetch_pc_d = redirect ? redirect_pc : target_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            head_pc_q  <= 64'h0;
            head_ins_q <= 32'h0;
            tail_pc_q  <= 64'h0;
            tail_ins_q <= 32'h0;
            count_q    <= 2'd0;
            status_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            head_pc_q  <= head_pc_d;
            head_ins_q <= head_ins_d;
            tail_pc_q  <= tail_pc_d;
            tail_ins_q <= tail_ins_d;
            count_q    <= count_d;
            status_q   <= status_d;
        end
    end

    always_comb begin
        imem_req    = (state_q == FETCH) || (state_q == DRAIN);
        imem_addr   = fetch_pc_q;
        instruction = head_ins_q;
        instr_pc    = head_pc_q;
        instr_valid = (count_q != 2'd0);
        status      = status_q;
    end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit with a behavioural instruction memory
// and a scoreboard of the words expected to reach the control unit.
module tb_legv8_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic        status_we = 1'b0;
    logic [4:0]  status_in = 5'd0;
    logic [4:0]  status;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    bit          discard = 1'b0;
    logic [63:0] exp_addr = 64'h0;

    legv8_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_data       (imem_data),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .status_we       (status_we),
        .status_in       (status_in),
        .status          (status)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B1F0040;
        if (a == 64'h4) return 32'hCB0003E0;
        return 32'hA5000000 ^ a[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    {63'h0, imem_req},    64'h0);
        check({tag, "_addr"},   imem_addr,            64'h0);
        check({tag, "_ivalid"}, {63'h0, instr_valid}, 64'h0);
        check({tag, "_instr"},  {32'h0, instruction}, 64'h0);
        check({tag, "_ipc"},    instr_pc,             64'h0);
        check({tag, "_status"}, {59'h0, status},      64'h0);
    endtask

    // Called just after a falling edge: checks the queue head, answers the
    // memory request, records what should be enqueued, then advances one cycle.
    task automatic step(input logic rdy, input logic rd, input logic [63:0] tgt,
                        input logic swe, input logic [4:0] sin);
        entry_t e;
        instr_ready     = rdy;
        redirect        = rd;
        redirect_target = tgt;
        status_we       = swe;
        status_in       = sin;
        check("instr_valid", {63'h0, instr_valid}, {63'h0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            check("instruction", {32'h0, instruction}, {32'h0, sb[0].ins});
            check("instr_pc", instr_pc, sb[0].pc);
            if (rdy && !rd) void'(sb.pop_front());
        end
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        if (imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_valid = 1'b1;
                imem_data  = mem_word(imem_addr);
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (rd) begin
            sb.delete();
            discard  = imem_req && !imem_valid;
            exp_addr = tgt & ~64'h3;
        end else if (imem_valid) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                check("fetch_addr", imem_addr, exp_addr);
                e.pc  = exp_addr;
                e.ins = mem_word(exp_addr);
                sb.push_back(e);
                exp_addr = exp_addr + 64'd4;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        status_we   = 1'b0;
        imem_valid  = 1'b0;
        imem_data   = 32'h0;
        sb.delete();
        discard  = 1'b0;
        wait_cnt = 0;
        exp_addr = 64'h0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_first_req"},  {63'h0, imem_req}, 64'h1);
        check({tag, "_first_addr"}, imem_addr,         64'h0);
    endtask

    initial begin
        // Power-on reset and first request
        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("first_req",  {63'h0, imem_req}, 64'h1);
        check("first_addr", imem_addr,         64'h0);

        // Reset then fetch with zero-wait memory
        mem_wait = 0;
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("seq_addr_4", imem_addr, 64'h4);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("seq_addr_8", imem_addr, 64'h8);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);

        // Backpressure
        do_reset("rst_bp");
        step(1'b0, 1'b0, 64'h0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 5'd0);
        check("full_req",  {63'h0, imem_req}, 64'h0);
        check("full_addr", imem_addr,         64'h8);
        step(1'b0, 1'b0, 64'h0, 1'b0, 5'd0);
        check("full_hold_req",  {63'h0, imem_req}, 64'h0);
        check("full_hold_addr", imem_addr,         64'h8);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("refetch_req",  {63'h0, imem_req}, 64'h1);
        check("refetch_addr", imem_addr,         64'h8);
        step(1'b0, 1'b0, 64'h0, 1'b0, 5'd0);
        check("single_refetch_req",  {63'h0, imem_req}, 64'h0);
        check("single_refetch_addr", imem_addr,         64'hC);

        // Redirect while the 0x4 request waits on a slow memory
        do_reset("rst_redir");
        mem_wait = 3;
        repeat (5) step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("pending_addr", imem_addr, 64'h4);
        step(1'b1, 1'b1, 64'h103, 1'b0, 5'd0);
        check("drain_req",  {63'h0, imem_req}, 64'h1);
        check("drain_addr", imem_addr,         64'h4);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("drain_hold_req",  {63'h0, imem_req}, 64'h1);
        check("drain_hold_addr", imem_addr,         64'h4);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        check("target_req",  {63'h0, imem_req},    64'h1);
        check("target_addr", imem_addr,            64'h100);
        check("drained_gone", {63'h0, instr_valid}, 64'h0);
        mem_wait = 0;
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);

        // Redirect, response and dequeue on the same edge with one entry queued
        check("simul_count1", {63'h0, instr_valid}, 64'h1);
        step(1'b1, 1'b1, 64'h200, 1'b0, 5'd0);
        check("simul_ivalid", {63'h0, instr_valid}, 64'h0);
        check("simul_req",    {63'h0, imem_req},    64'h1);
        check("simul_addr",   imem_addr,            64'h200);

        // Status register
        step(1'b1, 1'b0, 64'h0, 1'b1, 5'b10110);
        check("status_write", {59'h0, status}, {59'h0, 5'b10110});
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'b01001);
        check("status_hold1", {59'h0, status}, {59'h0, 5'b10110});
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'b01001);
        check("status_hold2", {59'h0, status}, {59'h0, 5'b10110});

        // Asynchronous reset while draining
        mem_wait = 3;
        step(1'b1, 1'b1, 64'h300, 1'b0, 5'd0);
        check("mid_drain_req",    {63'h0, imem_req},    64'h1);
        check("mid_drain_ivalid", {63'h0, instr_valid}, 64'h0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        do_reset("rst_async");
        mem_wait = 0;
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
